// File: rtl/i2c_eeprom_master_if.sv
// Command/status bundle between the register block and the I2C engine,
// plus the open-drain SCL/SDA controls that go to the top-level pad.
interface i2c_eeprom_master_if;
    logic       start;
    logic       cmd_rw;
    logic [6:0] dev_addr;
    logic [7:0] word_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rd_data;
    logic       scl_o;
    logic       sda_oe;
    logic       sda_i;

    // Register block / pad side: issues commands and returns the SDA pad level
    modport master (
        output start, cmd_rw, dev_addr, word_addr, wr_data, sda_i,
        input  busy, done, ack_err, rd_data, scl_o, sda_oe
    );

    // Engine side: consumes commands, reports status, drives the lines
    modport slave (
        input  start, cmd_rw, dev_addr, word_addr, wr_data, sda_i,
        output busy, done, ack_err, rd_data, scl_o, sda_oe
    );
endinterface

// File: rtl/i2c_eeprom_master.sv
// Byte-level I2C master for AT24C02-class EEPROMs: runs one byte-write or
// random-read transaction per accepted start, built from quarter-phase ticks.
module i2c_eeprom_master #(
    parameter int HZ_COUNTER = 120
) (
    input  logic               clk,
    input  logic               rst,
    i2c_eeprom_master_if.slave bus
);
    localparam int CW = $clog2(HZ_COUNTER);
    localparam logic [CW-1:0] TICK_LAST = CW'(HZ_COUNTER - 1);

    typedef enum logic [3:0] {
        IDLE, START, TX_BYTE, RX_ACK, RESTART, RX_BYTE, TX_NACK, STOP, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [7:0]    tx_sr_q, tx_sr_d;
    logic [7:0]    rx_sr_q, rx_sr_d;
    logic          cmd_rw_q, cmd_rw_d;
    logic [6:0]    dev_addr_q, dev_addr_d;
    logic [7:0]    word_addr_q, word_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          ack_err_q, ack_err_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          scl_q, scl_d;
    logic          sda_oe_q, sda_oe_d;
    logic          tick;
    logic          unit_end;
    logic          sample;

    // Line levels {scl, sda_oe} for a given position inside a 4-phase unit
    function automatic logic [1:0] line_levels(state_t st, logic [1:0] ph, logic tx_bit);
        logic scl_hi;
        scl_hi = (ph == 2'd1) || (ph == 2'd2);
        case (st)
            START, RESTART: line_levels = (ph == 2'd0) ? 2'b10 : (ph == 2'd3) ? 2'b01 : 2'b11;
            TX_BYTE:        line_levels = {scl_hi, ~tx_bit};
            RX_ACK, RX_BYTE, TX_NACK: line_levels = {scl_hi, 1'b0};
            STOP:           line_levels = (ph == 2'd0) ? 2'b01 : (ph == 2'd3) ? 2'b10 : 2'b11;
            default:        line_levels = 2'b10;
        endcase
    endfunction

    assign tick     = (cnt_q == TICK_LAST);
    assign unit_end = tick && (phase_q == 2'd3);
    assign sample   = tick && (phase_q == 2'd2);

    // Next-state: quarter-phase timing, bit/byte sequencing and status updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        cmd_rw_d    = cmd_rw_q;
        dev_addr_d  = dev_addr_q;
        word_addr_d = word_addr_q;
        wr_data_d   = wr_data_q;
        ack_err_d   = ack_err_q;
        rd_data_d   = rd_data_q;

        if ((state_q == IDLE) || (state_q == DONE)) begin
            cnt_d   = '0;
            phase_d = 2'd0;
        end else begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
            if (tick) phase_d = phase_q + 2'd1;
        end

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    cmd_rw_d    = bus.cmd_rw;
                    dev_addr_d  = bus.dev_addr;
                    word_addr_d = bus.word_addr;
                    wr_data_d   = bus.wr_data;
                    ack_err_d   = 1'b0;
                    state_d     = START;
                end
            end
            START: if (unit_end) begin
                state_d = TX_BYTE;
                tx_sr_d = {dev_addr_q, 1'b0};
                bit_d   = 3'd0;
                byte_d  = 2'd0;
            end
            RESTART: if (unit_end) begin
                state_d = TX_BYTE;
                tx_sr_d = {dev_addr_q, 1'b1};
                bit_d   = 3'd0;
                byte_d  = 2'd2;
            end
            TX_BYTE: if (unit_end) begin
                if (bit_q == 3'd7) begin
                    state_d = RX_ACK;
                end else begin
                    bit_d   = bit_q + 3'd1;
                    tx_sr_d = {tx_sr_q[6:0], 1'b0};
                end
            end
            RX_ACK: begin
                if (sample && bus.sda_i) ack_err_d = 1'b1;
                if (unit_end) begin
                    bit_d = 3'd0;
                    if (ack_err_q) begin
                        state_d = STOP;
                    end else if (byte_q == 2'd0) begin
                        state_d = TX_BYTE;
                        tx_sr_d = word_addr_q;
                        byte_d  = 2'd1;
                    end else if (byte_q == 2'd1) begin
                        if (cmd_rw_q) begin
                            state_d = RESTART;
                        end else begin
                            state_d = TX_BYTE;
                            tx_sr_d = wr_data_q;
                            byte_d  = 2'd2;
                        end
                    end else begin
                        state_d = cmd_rw_q ? RX_BYTE : STOP;
                    end
                end
            end
            RX_BYTE: begin
                if (sample) rx_sr_d = {rx_sr_q[6:0], bus.sda_i};
                if (unit_end) begin
                    if (bit_q == 3'd7) state_d = TX_NACK;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            TX_NACK: if (unit_end) state_d = STOP;
            STOP: if (unit_end) begin
                state_d = DONE;
                if (cmd_rw_q && !ack_err_q) rd_data_d = rx_sr_q;
            end
            default: state_d = IDLE;
        endcase

        {scl_d, sda_oe_d} = line_levels(state_d, phase_d, tx_sr_d[7]);
    end

    // State and line registers; reset releases both lines immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phase_q     <= 2'd0;
            bit_q       <= 3'd0;
            byte_q      <= 2'd0;
            tx_sr_q     <= 8'h00;
            rx_sr_q     <= 8'h00;
            cmd_rw_q    <= 1'b0;
            dev_addr_q  <= 7'h00;
            word_addr_q <= 8'h00;
            wr_data_q   <= 8'h00;
            ack_err_q   <= 1'b0;
            rd_data_q   <= 8'h00;
            scl_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            cmd_rw_q    <= cmd_rw_d;
            dev_addr_q  <= dev_addr_d;
            word_addr_q <= word_addr_d;
            wr_data_q   <= wr_data_d;
            ack_err_q   <= ack_err_d;
            rd_data_q   <= rd_data_d;
            scl_q       <= scl_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    assign bus.busy    = (state_q != IDLE) && (state_q != DONE);
    assign bus.done    = (state_q == DONE);
    assign bus.ack_err = ack_err_q;
    assign bus.rd_data = rd_data_q;
    assign bus.scl_o   = scl_q;
    assign bus.sda_oe  = sda_oe_q;
endmodule
